// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue and its fetch controller.
package instr_fetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } ifq_state_e;

    typedef logic [127:0] ifq_line_t;

    localparam int IFQ_LINE_BYTES = 16;

endpackage

// File: rtl/instr_fetch_queue_fetch_ctrl.sv
// Fetch controller: one outstanding line request, o_rd_en registered from IDLE and held until the response.
// A redirect during an outstanding request moves to DROP so the stale line is discarded on arrival.
module ifq_fetch_ctrl
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic [31:0] i_jmp_addr,
    input  logic        i_full,
    input  logic        i_dout_valid,
    output logic [31:0] o_pc_out,
    output logic        o_rd_en,
    output logic        o_wr_en
);

    ifq_state_e  state;
    logic [31:0] fetch_pc;

    assign o_pc_out = fetch_pc & ~32'hF;
    assign o_wr_en  = (state == WAIT) && i_dout_valid && !i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            o_rd_en  <= 1'b0;
        end else if (i_flush) begin
            fetch_pc <= i_jmp_addr & ~32'h3;
            o_rd_en  <= 1'b0;
            case (state)
                IDLE:    state <= IDLE;
                WAIT:    state <= i_dout_valid ? IDLE : DROP;
                // The stale response is still owed; only its arrival ends DROP.
                DROP:    state <= i_dout_valid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (!i_full) begin
                        state   <= WAIT;
                        o_rd_en <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_dout_valid) begin
                        state    <= IDLE;
                        o_rd_en  <= 1'b0;
                        fetch_pc <= (fetch_pc & ~32'hF) + 32'(IFQ_LINE_BYTES);
                    end
                end
                DROP: begin
                    if (i_dout_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH cache lines, one instruction per cycle to dispatch, line visible the cycle after its write.
// Fetch stalls while full; i_rd_en pops only when non-empty; IFQ_PERF_CNT_EN adds the o_starve_cnt counter.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic [31:0]  i_jmp_addr,
    output logic [31:0]  o_pc_out,
    output logic         o_rd_en,
    input  logic [127:0] i_dout,
    input  logic         i_dout_valid,
    output logic [31:0]  o_instr,
    output logic [31:0]  o_pc,
    output logic         o_empty,
    input  logic         i_rd_en
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]  o_starve_cnt
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] LAST_OFF = 2'(LINE_WORDS - 1);

    ifq_line_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    rd_off;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = i_rd_en && !empty && !i_flush;
    assign o_empty = empty;
    assign o_instr = mem[rd_ptr[AW-1:0]][{rd_off, 5'd0} +: 32];

    ifq_fetch_ctrl #(
        .RESET_PC (RESET_PC)
    ) u_fetch_ctrl (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_jmp_addr   (i_jmp_addr),
        .i_full       (full),
        .i_dout_valid (i_dout_valid),
        .o_pc_out     (o_pc_out),
        .o_rd_en      (o_rd_en),
        .o_wr_en      (wr_en)
    );

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_dout;
        end
    end

    // Push and line-free in the same cycle are independent, so occupancy holds.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_off <= RESET_PC[3:2];
            o_pc   <= RESET_PC;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_off <= i_jmp_addr[3:2];
            o_pc   <= i_jmp_addr & ~32'h3;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_off <= rd_off + 2'd1;
                o_pc   <= o_pc + 32'd4;
                if (rd_off == LAST_OFF) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end
        end
    end

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_starve_cnt <= '0;
        end else if (empty && !i_flush && (o_starve_cnt != 32'hFFFF_FFFF)) begin
            o_starve_cnt <= o_starve_cnt + 32'd1;
        end
    end
`else
    // No starvation counter in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a behavioural single-outstanding cache model.
module tb_instr_fetch_queue;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_flush;
    logic [31:0]  i_jmp_addr;
    logic [31:0]  o_pc_out;
    logic         o_rd_en;
    logic [127:0] i_dout;
    logic         i_dout_valid;
    logic [31:0]  o_instr;
    logic [31:0]  o_pc;
    logic         o_empty;
    logic         i_rd_en;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]  o_starve_cnt;
`endif

    instr_fetch_queue #(
        .DEPTH      (4),
        .LINE_WORDS (4),
        .RESET_PC   (RST_PC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_jmp_addr   (i_jmp_addr),
        .o_pc_out     (o_pc_out),
        .o_rd_en      (o_rd_en),
        .i_dout       (i_dout),
        .i_dout_valid (i_dout_valid),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_empty      (o_empty),
        .i_rd_en      (i_rd_en)
`ifdef IFQ_PERF_CNT_EN
        ,
        .o_starve_cnt (o_starve_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction word stored in the model cache at a given PC.
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
        #1;
    endtask

    // Cache model: one request at a time, response lat cycles after the request is seen.
    int           lat = 1;
    int           resp_cnt = 0;
    logic [31:0]  req_addr;
    initial begin
        i_dout_valid = 1'b0;
        i_dout       = '0;
        forever begin
            @(negedge i_clk);
            if (o_rd_en === 1'b1 && i_rst_n === 1'b1) begin
                req_addr = o_pc_out;
                repeat (lat) @(negedge i_clk);
                for (int k = 0; k < 4; k++) begin
                    i_dout[32*k +: 32] = ins(req_addr + 32'(4 * k));
                end
                i_dout_valid = 1'b1;
                resp_cnt++;
                @(negedge i_clk);
                i_dout_valid = 1'b0;
            end
        end
    end

    // Reference count of cycles that end with the queue empty and no flush.
    int starve_model = 0;
    initial begin
        forever begin
            @(posedge i_clk);
            if (i_rst_n !== 1'b1) starve_model = 0;
            else if (o_empty === 1'b1 && i_flush === 1'b0) starve_model++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        flush;
        logic [31:0] jmp;
        logic        rd;
        logic        chk;
        logic        exp_empty;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_pc_out;
    } vec_t;

    vec_t tbl [11];

    initial begin : main
        int          quiet;
        int          gaps;
        bit          found;
        bit          started;
        logic [31:0] exp;
        logic [2:0]  occ;

        // Flush to an unaligned target from an idle, full queue; one row per cycle.
        tbl[0]  = '{1'b1, 32'h0000_1008, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_1008, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_1008, 1'b1, 32'h0000_1000};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_1008, 1'b1, 32'h0000_1000};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_1008, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_100C, 1'b1, 32'h0000_1010};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_1010, 1'b1, 32'h0000_1010};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_1010, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1014, 1'b1, 32'h0000_1020};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_1014, 1'b1, 32'h0000_1020};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_1018, 1'b0, 32'h0};

        i_rst_n    = 1'b0;
        i_flush    = 1'b0;
        i_jmp_addr = '0;
        i_rd_en    = 1'b0;
        repeat (3) cyc();
        chk("reset_empty", {31'd0, o_empty}, 32'd1);
        chk("reset_rd_en", {31'd0, o_rd_en}, 32'd0);
        chk("reset_pc", o_pc, RST_PC);

        // First request right after reset release, then first instruction.
        i_rst_n = 1'b1;
        cyc();
        chk("boot_rd_en", {31'd0, o_rd_en}, 32'd1);
        chk("boot_pc_out", o_pc_out, RST_PC);
        for (int t = 0; t < 10 && o_empty; t++) cyc();
        chk("boot_empty", {31'd0, o_empty}, 32'd0);
        chk("boot_pc", o_pc, RST_PC);
        chk("boot_instr", o_instr, ins(RST_PC));

        // Dispatch stalled: exactly four lines fetched, then no more requests.
        repeat (20) cyc();
        chk("stall_lines", 32'(resp_cnt), 32'd4);
        chk("stall_full", {29'd0, dut.wr_ptr ^ dut.rd_ptr}, 32'd4);
        for (int t = 0; t < 5; t++) begin
            chk("stall_no_req", {31'd0, o_rd_en}, 32'd0);
            cyc();
        end

        // Pop one line's worth of words; a request for the next line follows.
        for (int t = 0; t < 4; t++) begin
            chk("pop_pc", o_pc, RST_PC + 32'(4 * t));
            chk("pop_instr", o_instr, ins(RST_PC + 32'(4 * t)));
            i_rd_en = 1'b1;
            cyc();
        end
        i_rd_en = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (o_rd_en) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("refetch_req", {31'd0, found}, 32'd1);
        chk("refetch_pc_out", o_pc_out, 32'h0040_0040);
        chk("refetch_head_pc", o_pc, 32'h0040_0010);
        chk("refetch_head_instr", o_instr, ins(32'h0040_0010));

        // Wait until the queue refills and fetch goes quiet.
        quiet = 0;
        for (int t = 0; t < 40 && quiet < 4; t++) begin
            cyc();
            quiet = o_rd_en ? 0 : quiet + 1;
        end
        chk("refill_quiet", 32'(quiet), 32'd4);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d_empty", i), {31'd0, o_empty}, {31'd0, tbl[i].exp_empty});
                chk($sformatf("vec%0d_pc", i), o_pc, tbl[i].exp_pc);
                chk($sformatf("vec%0d_rd_en", i), {31'd0, o_rd_en}, {31'd0, tbl[i].exp_req});
                if (tbl[i].exp_req)
                    chk($sformatf("vec%0d_pc_out", i), o_pc_out, tbl[i].exp_pc_out);
                if (!tbl[i].exp_empty)
                    chk($sformatf("vec%0d_instr", i), o_instr, ins(tbl[i].exp_pc));
            end
            i_flush    = tbl[i].flush;
            i_jmp_addr = tbl[i].jmp;
            i_rd_en    = tbl[i].rd;
            cyc();
        end
        i_flush = 1'b0;
        i_rd_en = 1'b0;

        // Flush while a request is outstanding; the stale line must never appear.
        quiet = 0;
        for (int t = 0; t < 40 && quiet < 4; t++) begin
            cyc();
            quiet = o_rd_en ? 0 : quiet + 1;
        end
        lat = 3;
        i_flush    = 1'b1;
        i_jmp_addr = 32'h0000_2000;
        cyc();
        i_flush = 1'b0;
        cyc();
        chk("drop_req", {31'd0, o_rd_en}, 32'd1);
        chk("drop_req_pc_out", o_pc_out, 32'h0000_2000);
        i_flush    = 1'b1;
        i_jmp_addr = 32'h0000_3000;
        cyc();
        i_flush = 1'b0;
        lat = 1;
        chk("drop_rd_en_low", {31'd0, o_rd_en}, 32'd0);
        found = 1'b0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (o_rd_en && o_pc_out == 32'h0000_3000) begin
                found = 1'b1;
                break;
            end
            chk("drop_still_empty", {31'd0, o_empty}, 32'd1);
        end
        chk("drop_new_req", {31'd0, found}, 32'd1);
        for (int t = 0; t < 10 && o_empty; t++) cyc();
        chk("drop_first_pc", o_pc, 32'h0000_3000);
        chk("drop_first_instr", o_instr, ins(32'h0000_3000));

        // Flush coinciding with a response and a dispatch read.
        found = 1'b0;
        for (int t = 0; t < 20; t++) begin
            cyc();
            if (i_dout_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("coll_valid_seen", {31'd0, found}, 32'd1);
        i_flush    = 1'b1;
        i_jmp_addr = 32'h0000_5004;
        i_rd_en    = 1'b1;
        cyc();
        i_flush = 1'b0;
        i_rd_en = 1'b0;
        chk("coll_empty", {31'd0, o_empty}, 32'd1);
        chk("coll_pc", o_pc, 32'h0000_5004);
        chk("coll_rd_en", {31'd0, o_rd_en}, 32'd0);
        chk("coll_wr_ptr", {29'd0, dut.wr_ptr}, 32'd0);
        chk("coll_rd_ptr", {29'd0, dut.rd_ptr}, 32'd0);
        cyc();
        chk("coll_restart", {31'd0, o_rd_en}, 32'd1);
        chk("coll_restart_pc_out", o_pc_out, 32'h0000_5000);

        // Continuous dispatch: gap-free PC stream across line boundaries.
        i_rd_en = 1'b1;
        exp     = 32'h0000_5004;
        gaps    = 0;
        started = 1'b0;
        for (int t = 0; t < 60; t++) begin
            cyc();
            occ = dut.wr_ptr - dut.rd_ptr;
            if (!o_empty) begin
                started = 1'b1;
                chk("stream_pc", o_pc, exp);
                chk("stream_instr", o_instr, ins(exp));
                if (o_pc == 32'h0000_500C || o_pc == 32'h0000_5010)
                    chk("stream_occupancy", {29'd0, occ}, 32'd1);
                exp = exp + 32'd4;
            end else if (started) begin
                gaps++;
            end
        end
        i_rd_en = 1'b0;
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_started", {31'd0, started}, 32'd1);

`ifdef IFQ_PERF_CNT_EN
        chk("starve_cnt", o_starve_cnt, 32'(starve_model));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
